// File: rtl/mul_pkg.sv
// Shared constants, opcode encodings and small helpers for the 32x32 multiplier.
// Only opcode[1:0] carries meaning; the remaining opcode bits are ignored.
package mul_pkg;

    localparam int WIDTH = 32;
    localparam int HALF  = WIDTH / 2;

    typedef enum logic [1:0] {
        MUL_UU  = 2'b00,
        MUL_SS  = 2'b01,
        MUL_SU  = 2'b10,
        MUL_RSV = 2'b11
    } mul_op_e;

    typedef struct packed {
        logic a_signed;
        logic b_signed;
    } op_decode_t;

    // Reserved encoding falls through to the unsigned interpretation.
    function automatic op_decode_t decode_op(input logic [1:0] op);
        op_decode_t d;
        d.a_signed = 1'b0;
        d.b_signed = 1'b0;
        case (mul_op_e'(op))
            MUL_SS:  begin d.a_signed = 1'b1; d.b_signed = 1'b1; end
            MUL_SU:  begin d.a_signed = 1'b1; d.b_signed = 1'b0; end
            default: begin d.a_signed = 1'b0; d.b_signed = 1'b0; end
        endcase
        return d;
    endfunction

    // Magnitude of a possibly negative operand; -2^31 maps to 2^31 as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             neg);
        return neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

endpackage

// File: rtl/mul16x16.sv
// Unsigned 16x16 -> 32-bit combinational multiplier used for one partial product.
module mul16x16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [31:0] p_o
);

    assign p_o = {16'b0, a_i} * {16'b0, b_i};

endmodule

// File: rtl/multiply.sv
// Two-stage 32x32 -> 64 multiplier: stage 1 registers magnitudes, result sign and
// four 16x16 partials; stage 2 sums the partials and applies the sign.
module multiply
    import mul_pkg::*;
#(
    parameter int WIDTH = mul_pkg::WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [6:0]           opcode,
    output logic [2*WIDTH-1:0]   product
);

    localparam int H = WIDTH / 2;

    // Free-running pipeline with no handshake: a new operand pair is accepted
    // every cycle and its product appears after the second rising edge.

    op_decode_t             dec;
    logic                   a_neg;
    logic                   b_neg;
    logic [WIDTH-1:0]       mag_a_d;
    logic [WIDTH-1:0]       mag_b_d;
    logic                   neg_d;
    logic [3:0][WIDTH-1:0]  pp_d;
    logic                   unused_opcode_hi;

    logic [WIDTH-1:0]       mag_a_q;
    logic [WIDTH-1:0]       mag_b_q;
    logic                   neg_q;
    logic [3:0][WIDTH-1:0]  pp_q;

    logic [2*WIDTH-1:0]     sum_d;
    logic [2*WIDTH-1:0]     product_d;
    logic [2*WIDTH-1:0]     product_q;

    assign unused_opcode_hi = ^opcode[6:2];

    // ---------------------------------------------------------------- stage 1
    always_comb begin
        dec     = decode_op(opcode[1:0]);
        a_neg   = dec.a_signed & multiplicand[WIDTH-1];
        b_neg   = dec.b_signed & multiplier[WIDTH-1];
        mag_a_d = magnitude(multiplicand, a_neg);
        mag_b_d = magnitude(multiplier, b_neg);
        neg_d   = a_neg ^ b_neg;
    end

    // Partial products: [0]=lo*lo, [1]=lo*hi, [2]=hi*lo, [3]=hi*hi.
    mul16x16 u_pp_ll (
        .a_i (mag_a_d[H-1:0]),
        .b_i (mag_b_d[H-1:0]),
        .p_o (pp_d[0])
    );

    mul16x16 u_pp_lh (
        .a_i (mag_a_d[H-1:0]),
        .b_i (mag_b_d[WIDTH-1:H]),
        .p_o (pp_d[1])
    );

    mul16x16 u_pp_hl (
        .a_i (mag_a_d[WIDTH-1:H]),
        .b_i (mag_b_d[H-1:0]),
        .p_o (pp_d[2])
    );

    mul16x16 u_pp_hh (
        .a_i (mag_a_d[WIDTH-1:H]),
        .b_i (mag_b_d[WIDTH-1:H]),
        .p_o (pp_d[3])
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_a_q <= '0;
            mag_b_q <= '0;
            neg_q   <= 1'b0;
            pp_q    <= '0;
        end else begin
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            neg_q   <= neg_d;
            pp_q    <= pp_d;
        end
    end

    // ---------------------------------------------------------------- stage 2
    always_comb begin
        sum_d = {{WIDTH{1'b0}}, pp_q[0]}
              + ({{WIDTH{1'b0}}, pp_q[1]} << H)
              + ({{WIDTH{1'b0}}, pp_q[2]} << H)
              + {pp_q[3], {WIDTH{1'b0}}};
        product_d = neg_q ? (~sum_d + {{(2*WIDTH-1){1'b0}}, 1'b1}) : sum_d;
        // A zero operand must never yield a negated (nonzero) pattern.
        if (mag_a_q == '0 || mag_b_q == '0) begin
            product_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            product_q <= '0;
        end else begin
            product_q <= product_d;
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_multiply.sv
// Randomized and directed bench for the two-stage multiplier, checked against a
// signed/unsigned arithmetic reference model.
module tb_multiply;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [6:0]  opcode;
    logic [63:0] product;

    int n_checks;
    int n_pass;

    logic [63:0] exp_q[$];

    multiply dut (
        .clk          (clk),
        .rst          (rst),
        .multiplicand (a),
        .multiplier   (b),
        .opcode       (opcode),
        .product      (product)
    );

    // ------------------------------------------------------ clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------ reference model
    function automatic logic [63:0] ref_mul(input logic [31:0] x,
                                            input logic [31:0] y,
                                            input logic [1:0]  op);
        longint sx;
        longint sy;
        case (op)
            2'b01: begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
            end
            2'b10: begin
                sx = longint'($signed(x));
                sy = longint'({32'b0, y});
            end
            default: begin
                sx = longint'({32'b0, x});
                sy = longint'({32'b0, y});
            end
        endcase
        return 64'(sx * sy);
    endfunction

    // ------------------------------------------------------ checking
    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------ driver tasks
    task automatic drive(input logic [31:0] x, input logic [31:0] y,
                         input logic [6:0] op);
        a      = x;
        b      = y;
        opcode = op;
    endtask

    task automatic run_op(input string tag, input logic [31:0] x,
                          input logic [31:0] y, input logic [6:0] op,
                          input logic [63:0] exp);
        @(negedge clk);
        drive(x, y, op);
        repeat (2) @(posedge clk);
        #1;
        check(tag, product, exp);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = 32'h7FFF_FFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // ------------------------------------------------------ stimulus
    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        drive(32'd0, 32'd0, 7'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", product, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // reset mid-stream: nonzero result in flight, then asynchronous clear
        run_op("pre_reset", 32'd7, 32'd9, 7'd0, 64'd63);
        @(negedge clk);
        drive(32'd50, 32'd50, 7'd0);
        rst = 1'b1;
        #1;
        check("reset_async", product, 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_flush", product, 64'd0);
        @(posedge clk);
        #1;
        check("reset_recover", product, 64'd2500);
        run_op("post_reset_b0", 32'd50, 32'd0, 7'd0, 64'd0);

        // unsigned
        run_op("uu_50x50", 32'd50, 32'd50, 7'd0, 64'd2500);
        @(posedge clk);
        #1;
        check("uu_hold", product, 64'd2500);
        run_op("uu_50x1000", 32'd50, 32'd1000, 7'd0, 64'd50000);
        run_op("uu_50xmax", 32'd50, 32'hFFFF_FFFF, 7'd0, 64'h0000_0031_FFFF_FFCE);
        run_op("uu_maxxmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'd0, 64'hFFFF_FFFE_0000_0001);
        run_op("rsv_maxxmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'd3, 64'hFFFF_FFFE_0000_0001);
        run_op("uu_hi_bits_ignored", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'b1111100,
               64'hFFFF_FFFE_0000_0001);

        // signed
        run_op("ss_m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'd1, 64'd1);
        run_op("ss_m1x50", 32'hFFFF_FFFF, 32'd50, 7'd1, 64'hFFFF_FFFF_FFFF_FFCE);
        run_op("ss_minxmin", 32'h8000_0000, 32'h8000_0000, 7'd1, 64'h4000_0000_0000_0000);
        run_op("ss_minx1", 32'h8000_0000, 32'd1, 7'd1, 64'hFFFF_FFFF_8000_0000);
        run_op("ss_negx0", 32'hFFFF_FFF6, 32'd0, 7'd1, 64'd0);

        // mixed sign
        run_op("su_m1xmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'd2, 64'hFFFF_FFFF_0000_0001);
        run_op("su_negx0", 32'h8000_0000, 32'd0, 7'd2, 64'd0);
        run_op("su_pos_b_msb", 32'd3, 32'h8000_0000, 7'd2, 64'h0000_0001_8000_0000);

        // back-to-back random stream, results checked in order two cycles later
        exp_q.delete();
        for (int i = 0; i < 100; i++) begin
            logic [31:0] x;
            logic [31:0] y;
            logic [6:0]  op;
            @(negedge clk);
            if (exp_q.size() == 2) begin
                check($sformatf("stream_%0d", i - 2), product, exp_q.pop_front());
            end
            x  = rand_operand();
            y  = rand_operand();
            op = 7'($urandom_range(0, 127));
            drive(x, y, op);
            exp_q.push_back(ref_mul(x, y, op[1:0]));
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("stream_drain_%0d", i), product, exp_q.pop_front());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
